// File: rtl/g7_pkg.sv
// Shared types and constants for the Guide 07 stimulus/capture sequencer.
package g7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } g7_state_t;

  localparam int         G7_NUM_VECTORS      = 8;
  localparam logic [7:0] G7_EXPECTED_DEFAULT = 8'h95;

  // Operand triple {x, y, select} for a vector index.
  function automatic logic [2:0] g7_vec(input logic [2:0] idx);
    return {idx[2], idx[1], ~idx[0]};
  endfunction

endpackage

// File: rtl/g7_step_timer.sv
// Modulo-STEP_CYCLES settle counter; tick marks the last cycle of a vector.
module g7_step_timer #(
  parameter int STEP_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            W    = $clog2(STEP_CYCLES + 1);
  localparam logic [W-1:0]  LAST = W'(STEP_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/g7_stimulus_seq.sv
// Steps the AND/NAND mux datapath through all eight vectors, captures s_in
// per vector into result and compares the word against a golden value.
module g7_stimulus_seq
  import g7_pkg::*;
#(
  parameter int         STEP_CYCLES = 2,
  parameter logic [7:0] EXPECTED    = G7_EXPECTED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic       select,
  output logic       busy,
  output logic       valid,
  output logic       done,
  output logic [7:0] result,
  output logic       pass
);

  localparam logic [2:0] LAST_IDX = 3'(G7_NUM_VECTORS - 1);

  g7_state_t  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ops_q, ops_d;
  logic [7:0] result_q, result_d;
  logic       pass_q, pass_d;
  logic       tick;
  logic       timer_en, timer_clr;

  assign timer_en  = (state_q == RUN) && !hold;
  assign timer_clr = (state_q == IDLE) && start;

  g7_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .en_i   (timer_en),
    .clr_i  (timer_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ops_d    = ops_q;
    result_d = result_q;
    pass_d   = pass_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        idx_d    = '0;
        ops_d    = g7_vec(3'd0);
        result_d = '0;
        pass_d   = 1'b0;
      end
      RUN: if (tick) begin
        result_d[idx_q] = s_in;
        idx_d           = idx_q + 3'd1;
        // Last vector keeps its operands on the bus after the run.
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          pass_d  = (result_d == EXPECTED);
        end else begin
          ops_d = g7_vec(idx_q + 3'd1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      ops_q    <= '0;
      result_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ops_q    <= ops_d;
      result_q <= result_d;
      pass_q   <= pass_d;
    end
  end

  assign {x, y, select} = ops_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign valid  = tick;
  assign result = result_q;
  assign pass   = pass_q;

endmodule

// File: tb/tb_g7_stimulus_seq.sv
// Self-checking bench: two sequencers (STEP_CYCLES 2 and 1) against a cycle-level reference model.
module tb_g7_stimulus_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, hold;
  logic [1:0] s_in, rnd;
  logic [1:0] o_x, o_y, o_sel, o_busy, o_valid, o_done, o_pass;
  logic [7:0] o_res [2];
  int         s_mode;  // 0 datapath, 1 tie 0, 2 tie 1, 3 random

  int checks = 0, failures = 0, cyc = 0;

  // Reference model state
  int         m_mode [2];  // 0 idle, 1 run, 2 done
  int         m_n    [2];  // non-held RUN cycles elapsed
  logic [7:0] m_res  [2];
  logic       m_pass [2];
  logic [2:0] m_ops  [2];

  // Observed statistics
  int         busy_cnt [2], valid_cnt [2], done_cnt [2];
  int         done_t   [2][4];
  logic [7:0] res_done [2];
  logic       pass_done [2];

  g7_stimulus_seq #(.STEP_CYCLES(2)) u_s2 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .s_in(s_in[0]),
    .x(o_x[0]), .y(o_y[0]), .select(o_sel[0]), .busy(o_busy[0]), .valid(o_valid[0]),
    .done(o_done[0]), .result(o_res[0]), .pass(o_pass[0]));

  g7_stimulus_seq #(.STEP_CYCLES(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .s_in(s_in[1]),
    .x(o_x[1]), .y(o_y[1]), .select(o_sel[1]), .busy(o_busy[1]), .valid(o_valid[1]),
    .done(o_done[1]), .result(o_res[1]), .pass(o_pass[1]));

  // ops = {x, y, select}; select=1 picks NAND, 0 picks AND
  function automatic logic dp(input logic [2:0] ops);
    logic a;
    a = ops[2] & ops[1];
    return ops[0] ? ~a : a;
  endfunction

  always_comb begin
    s_in = '0;
    for (int d = 0; d < 2; d++) begin
      case (s_mode)
        1:       s_in[d] = 1'b0;
        2:       s_in[d] = 1'b1;
        3:       s_in[d] = rnd[d];
        default: s_in[d] = dp({o_x[d], o_y[d], o_sel[d]});
      endcase
    end
  end

  function automatic logic [2:0] vec(input int k);
    logic [2:0] kk;
    kk = 3'(k);
    return {kk[2], kk[1], ~kk[0]};
  endfunction

  function automatic logic [15:0] obs(input int d);
    return {1'b0, o_x[d], o_y[d], o_sel[d], o_busy[d], o_valid[d], o_done[d], o_pass[d], o_res[d]};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_n[d] = 0; m_res[d] = '0; m_pass[d] = 1'b0; m_ops[d] = '0;
    end
  endtask

  task automatic clr_obs();
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0; valid_cnt[d] = 0; done_cnt[d] = 0;
      res_done[d] = '0; pass_done[d] = 1'b0;
      for (int i = 0; i < 4; i++) done_t[d][i] = -1;
    end
  endtask

  // One clock: compare every output against the model, advance the model.
  task automatic tick();
    logic [2:0]  ops;
    logic        run, vld, sm;
    logic [15:0] expb;
    int          s;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s    = (d == 0) ? 2 : 1;
      run  = (m_mode[d] == 1);
      ops  = run ? vec(m_n[d] / s) : m_ops[d];
      vld  = run && !hold && (m_n[d] % s == s - 1);
      expb = {1'b0, ops, run, vld, m_mode[d] == 2, m_pass[d], m_res[d]};
      chk(d == 0 ? "cycle_s2" : "cycle_s1", int'(obs(d)), int'(expb));
      busy_cnt[d]  += int'(o_busy[d]);
      valid_cnt[d] += int'(o_valid[d]);
      if (o_done[d]) begin
        if (done_cnt[d] < 4) done_t[d][done_cnt[d]] = cyc;
        done_cnt[d]++;
        res_done[d]  = o_res[d];
        pass_done[d] = o_pass[d];
      end
      if (reset) begin
        m_mode[d] = 0; m_n[d] = 0; m_res[d] = '0; m_pass[d] = 1'b0; m_ops[d] = '0;
      end else begin
        case (m_mode[d])
          0: if (start) begin
            m_mode[d] = 1; m_n[d] = 0; m_res[d] = '0; m_pass[d] = 1'b0;
          end
          1: begin
            m_ops[d] = ops;
            if (!hold) begin
              if (vld) begin
                sm = (s_mode == 0) ? dp(ops) : s_in[d];
                m_res[d][m_n[d] / s] = sm;
              end
              m_n[d]++;
              if (m_n[d] == 8 * s) begin
                m_mode[d] = 2;
                m_pass[d] = (m_res[d] == 8'h95);
              end
            end
          end
          default: m_mode[d] = 0;
        endcase
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    rnd = 2'($urandom);
  endtask

  task automatic run_one(input int mode, input logic [7:0] exp_res, input logic exp_pass);
    int t0;
    s_mode = mode;
    clr_obs();
    t0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    chk("done_cnt_s2", done_cnt[0], 1);
    chk("done_cnt_s1", done_cnt[1], 1);
    chk("done_time_s2", done_t[0][0], t0 + 17);
    chk("done_time_s1", done_t[1][0], t0 + 9);
    chk("busy_cycles_s2", busy_cnt[0], 16);
    chk("busy_cycles_s1", busy_cnt[1], 8);
    chk("valid_cnt_s2", valid_cnt[0], 8);
    chk("valid_cnt_s1", valid_cnt[1], 8);
    chk("result_s2", int'(res_done[0]), int'(exp_res));
    chk("result_s1", int'(res_done[1]), int'(exp_res));
    chk("pass_s2", int'(pass_done[0]), int'(exp_pass));
    chk("pass_s1", int'(pass_done[1]), int'(exp_pass));
  endtask

  initial begin
    int t0;
    reset = 1'b1; start = 1'b0; hold = 1'b0; s_mode = 0; rnd = '0;
    model_reset();
    clr_obs();
    #1;
    chk("reset_s2", int'(obs(0)), 0);
    chk("reset_s1", int'(obs(1)), 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    run_one(0, 8'h95, 1'b1);
    run_one(1, 8'h00, 1'b0);
    run_one(2, 8'hFF, 1'b0);

    // hold for three cycles at the start of vector 4 (STEP_CYCLES=2 instance)
    s_mode = 0; clr_obs(); t0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    hold = 1'b1;
    repeat (3) begin
      chk("hold_ops_s2", int'({o_x[0], o_y[0], o_sel[0]}), 5);
      tick();
    end
    hold = 1'b0;
    repeat (14) tick();
    chk("hold_done_time_s2", done_t[0][0], t0 + 20);
    chk("hold_done_time_s1", done_t[1][0], t0 + 9);
    chk("hold_result_s2", int'(res_done[0]), 'h95);
    chk("hold_done_cnt_s2", done_cnt[0], 1);

    // start repeated mid-run is ignored
    clr_obs(); t0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    chk("restart_done_cnt_s2", done_cnt[0], 1);
    chk("restart_done_cnt_s1", done_cnt[1], 1);
    chk("restart_done_time_s2", done_t[0][0], t0 + 17);
    chk("restart_done_time_s1", done_t[1][0], t0 + 9);

    // asynchronous reset during vector 5
    clr_obs(); t0 = cyc;
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("async_reset_s2", int'(obs(0)), 0);
    chk("async_reset_s1", int'(obs(1)), 0);
    model_reset();
    clr_obs();
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("no_done_after_reset_s2", done_cnt[0], 0);
    chk("no_done_after_reset_s1", done_cnt[1], 0);

    // start held high: back-to-back runs with one IDLE cycle in between
    clr_obs(); t0 = cyc;
    start = 1'b1;
    repeat (40) tick();
    start = 1'b0;
    repeat (4) tick();
    chk("b2b_first_s2", done_t[0][0], t0 + 17);
    chk("b2b_second_s2", done_t[0][1], t0 + 35);
    chk("b2b_first_s1", done_t[1][0], t0 + 9);
    chk("b2b_second_s1", done_t[1][1], t0 + 19);
    chk("b2b_result_s2", int'(res_done[0]), 'h95);
    chk("b2b_result_s1", int'(res_done[1]), 'h95);

    // randomized start/hold/s_in against the model
    repeat (400) begin
      if (cyc % 50 == 0) s_mode = int'($urandom_range(0, 3));
      start = ($urandom_range(0, 3) == 0);
      hold  = ($urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0; hold = 1'b0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/g7_stimulus_seq.md
# g7_stimulus_seq

Upstream stimulus-and-capture stage for the Guide 07 AND/NAND/mux datapath. On a start request it steps the datapath through all eight input vectors, which are every (x, y) pair with select=1 and then select=0. It holds each vector for a programmable settling time and samples the mux output returned on `s_in` into an 8-bit result word. When the run ends it flags completion and compares the word against a golden value.

## Interface
Parameters:
- `STEP_CYCLES`, default 2: clock cycles each vector is held; legal range 1..255.
- `EXPECTED`, default 8'h95: golden result word for the AND/NAND mux datapath.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  run request; sampled only in IDLE.
- `hold`  input  1  pauses the step timer while RUN.
- `s_in`  input  1  mux output from the downstream datapath.
- `x`  output  1  datapath operand x (registered).
- `y`  output  1  datapath operand y (registered).
- `select`  output  1  mux select (registered); 1 selects the NAND path, 0 the AND path.
- `busy`  output  1  high in RUN.
- `valid`  output  1  one-cycle pulse on each cycle `s_in` is sampled.
- `done`  output  1  one-cycle pulse in DONE.
- `result`  output  8  captured outputs; bit k holds the sample for vector k.
- `pass`  output  1  `result == EXPECTED`; updated in DONE, held until the next start.

## Operation
- FSM states:
  - IDLE: `start` → RUN and clear `idx`, `step`, `result`, `pass`.
  - RUN: stays in RUN until vector 7 is sampled, then → DONE.
  - DONE: `done`=1 and `pass` is updated; → IDLE unconditionally.
- Vector index `idx` is 3 bits: `{x, y} = idx[2:1]` and `select = ~idx[0]`. Order: 00/1, 00/0, 01/1, 01/0, 10/1, 10/0, 11/1, 11/0.
- Step counter `step` runs 0..STEP_CYCLES-1. When `step == STEP_CYCLES-1` and `hold` is 0:
  - `result[idx] <= s_in` and `valid` pulses.
  - `step` returns to 0 and `idx` increments.
  - If `idx` was 7, the FSM goes to DONE.
- `hold`=1 in RUN freezes `step` and `idx`, suppresses sampling, and keeps the operands stable. `hold` is ignored in IDLE and DONE.
- `start` in RUN or DONE is ignored; it is not queued.
- In IDLE and DONE, `x`, `y` and `select` keep their last driven values and `result` is held.
- Reset values: `x`=0, `y`=0, `select`=0, `busy`=0, `valid`=0, `done`=0, `result`=8'h00, `pass`=0, state=IDLE, `idx`=0, `step`=0.
- Reset asserted mid-run aborts immediately. No `done` pulse follows and all outputs return to their reset values.

## Timing
- `start`=1 at edge T: `busy`=1 and the vector-0 operands are driven from T+1.
- With no `hold`, vector k is driven during cycles T+1+k·STEP_CYCLES .. T+(k+1)·STEP_CYCLES.
- Vector k is sampled at the last of those cycles.
- Each `hold` cycle adds one cycle of latency to the run.
- `done` and the updated `pass` appear at cycle T+8·STEP_CYCLES+1, when `busy` drops. IDLE resumes the following cycle.
- `s_in` must be combinationally settled within STEP_CYCLES cycles of an operand change. The datapath is purely combinational, so STEP_CYCLES=1 is legal.

## Structure
- Shared package `g7_pkg` holds:
  - state enum `g7_state_t` {IDLE, RUN, DONE};
  - `G7_NUM_VECTORS` = 8;
  - `G7_EXPECTED_DEFAULT` = 8'h95.
- One sub-module, `g7_step_timer`:
  - parameterised modulo-STEP_CYCLES counter with enable (`busy & ~hold`);
  - emits a `tick` on its terminal count;
  - width is `$clog2(STEP_CYCLES+1)`.
- Top level holds the FSM, `idx`, the operand registers, the result shift-in and the compare logic.

## Test plan
- Reset, then `start` pulse with STEP_CYCLES=2 and the real f7a/f7b/mux datapath attached:
  - expect 16 RUN cycles and 8 `valid` pulses;
  - `result`=8'h95, `pass`=1, one `done` pulse at T+17.
- Same run with STEP_CYCLES=1: `done` at T+9 and `result`=8'h95.
- `s_in` tied to 0: `result`=8'h00 and `pass`=0. `s_in` tied to 1: `result`=8'hFF and `pass`=0.
- `hold` high for 3 cycles during vector 4:
  - operands stay at x=1, y=0, select=1 throughout the hold;
  - `done` is delayed by exactly 3 cycles and `result` is still 8'h95.
- `start` pulsed again mid-run: ignored, with a single `done` at the original time. Reset asserted during vector 5: all outputs go to their reset values immediately and no `done` follows.
- `start` held high continuously: back-to-back runs with one IDLE cycle between a `done` and the next `busy`. Each run yields 8'h95.
